// File: rtl/adc_lvds_pkg.sv
// Shared types and constants for the LVDS ADC receive path.
// Frame-alignment state encoding and per-resolution frame patterns.
package adc_lvds_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_LOCKED,
    ST_FAIL
  } align_state_t;

  localparam int SlipW = 6;

  localparam logic [7:0]  Pat8  = 8'hF0;
  localparam logic [9:0]  Pat10 = 10'h3E0;
  localparam logic [11:0] Pat12 = 12'hFC0;
  localparam logic [13:0] Pat14 = 14'h3F80;
  localparam logic [15:0] Pat16 = 16'hFF00;

  function automatic logic [15:0] default_pattern(input int bits);
    logic [15:0] p;
    case (bits)
      8:       p = {8'h00, Pat8};
      10:      p = {6'h00, Pat10};
      12:      p = {4'h0, Pat12};
      16:      p = Pat16;
      default: p = {2'b00, Pat14};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/adc_frame_match_filter.sv
// Consecutive match / mismatch counter for frame alignment.
// lock_hit and loss_hit fire combinationally on the threshold cycle.
module adc_frame_match_filter #(
  parameter int LockCount = 8,
  parameter int LossCount = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic check_en,
  input  logic mon_en,
  input  logic match,
  output logic lock_hit,
  output logic loss_hit
);

  localparam int MW = $clog2(LockCount) + 1;
  localparam int LW = $clog2(LossCount) + 1;

  logic [MW-1:0] match_cnt;
  logic [LW-1:0] loss_cnt;

  assign lock_hit = check_en && match &&
                    (match_cnt == MW'(LockCount - 1));
  assign loss_hit = mon_en && !match &&
                    (loss_cnt == LW'(LossCount - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt <= '0;
      loss_cnt  <= '0;
    end else begin
      if (!check_en || !match)
        match_cnt <= '0;
      else
        match_cnt <= match_cnt + MW'(1);
      // Any match while locked forgives earlier mismatches.
      if (!mon_en || match || loss_hit)
        loss_cnt <= '0;
      else
        loss_cnt <= loss_cnt + LW'(1);
    end
  end

endmodule

// File: rtl/adc_frame_align_ctrl.sv
// Frame-alignment sequencer: bitslips deserializers until the frame word
// matches, then holds lock and re-aligns on sustained mismatches.
module adc_frame_align_ctrl
  import adc_lvds_pkg::*;
#(
  parameter int          AdcBits      = 14,
  parameter logic [15:0] FramePattern = 16'h3F80,
  parameter int          SettleCycles = 4,
  parameter int          LockCount    = 8,
  parameter int          LossCount    = 4,
  parameter int          MaxSlips     = 2 * AdcBits
) (
  input  logic             FrmClk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [15:0]      FrameWord,
  output logic             BitSlip,
  output logic             Aligned,
  output logic             DataValid,
  output logic             AlignFail,
  output logic             LossOfLock,
  output logic [SlipW-1:0] SlipCount
);

  localparam logic [15:0] Mask = 16'hFFFF >> (16 - AdcBits);
  localparam int SW = $clog2(SettleCycles) + 1;

  align_state_t state;
  logic [SW-1:0] settle_cnt;
  logic match, lock_hit, loss_hit;

  assign match = ((FrameWord ^ FramePattern) & Mask) == 16'h0;

  adc_frame_match_filter #(
    .LockCount(LockCount),
    .LossCount(LossCount)
  ) u_filter (
    .clk     (FrmClk),
    .rst     (Rst),
    .check_en(state == ST_CHECK),
    .mon_en  (state == ST_LOCKED),
    .match   (match),
    .lock_hit(lock_hit),
    .loss_hit(loss_hit)
  );

  always_ff @(posedge FrmClk or posedge Rst) begin
    if (Rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      BitSlip    <= 1'b0;
      Aligned    <= 1'b0;
      DataValid  <= 1'b0;
      AlignFail  <= 1'b0;
      LossOfLock <= 1'b0;
      SlipCount  <= '0;
    end else begin
      BitSlip    <= 1'b0;
      LossOfLock <= 1'b0;
      DataValid  <= Aligned;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            SlipCount  <= '0;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SW'(SettleCycles - 1)) begin
            settle_cnt <= '0;
            state      <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        ST_CHECK: begin
          if (lock_hit) begin
            state   <= ST_LOCKED;
            Aligned <= 1'b1;
          end else if (!match) begin
            if (SlipCount == SlipW'(MaxSlips)) begin
              state     <= ST_FAIL;
              AlignFail <= 1'b1;
            end else begin
              state   <= ST_SLIP;
              BitSlip <= 1'b1;
              if (SlipCount != '1)
                SlipCount <= SlipCount + SlipW'(1);
            end
          end
        end
        ST_SLIP: begin
          state      <= ST_SETTLE;
          settle_cnt <= '0;
        end
        ST_LOCKED: begin
          // Loss takes priority over a coincident Start.
          if (loss_hit) begin
            LossOfLock <= 1'b1;
            Aligned    <= 1'b0;
            SlipCount  <= '0;
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end else if (Start) begin
            Aligned    <= 1'b0;
            SlipCount  <= '0;
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end
        end
        ST_FAIL: begin
          if (Start) begin
            AlignFail  <= 1'b0;
            SlipCount  <= '0;
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_frame_align_ctrl.sv
// Self-checking bench for adc_frame_align_ctrl with a bitslip-rotation
// model of the deserializer and a scoreboard of expected slip counts.
module tb_adc_frame_align_ctrl;

  localparam logic [13:0] Pat = 14'h3F80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic use_rot = 1'b0;
  logic [15:0] fixed_word = 16'h0000;
  logic [15:0] frame_word;
  logic [15:0] frame_word2 = 16'h0FC0;
  int off = 0;

  logic bit_slip, aligned, data_valid, align_fail, loss_of_lock;
  logic [5:0] slip_count;
  logic bs2, al2, dv2, af2, lol2;
  logic [5:0] sc2;

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [15:0] rot14(input logic [13:0] p, input int k);
    logic [13:0] r;
    r = (p << k) | (p >> (14 - k));
    return {2'b00, r};
  endfunction

  always_comb frame_word = use_rot ? rot14(Pat, off) : fixed_word;

  // Deserializer model: each bitslip moves the word one bit back.
  always @(posedge clk) if (bit_slip) off <= (off == 0) ? 13 : off - 1;

  adc_frame_align_ctrl u_dut (
    .FrmClk(clk), .Rst(rst), .Start(start), .FrameWord(frame_word),
    .BitSlip(bit_slip), .Aligned(aligned), .DataValid(data_valid),
    .AlignFail(align_fail), .LossOfLock(loss_of_lock),
    .SlipCount(slip_count)
  );

  adc_frame_align_ctrl #(.AdcBits(12), .FramePattern(16'hAFC0)) u_dut12 (
    .FrmClk(clk), .Rst(rst), .Start(start2), .FrameWord(frame_word2),
    .BitSlip(bs2), .Aligned(al2), .DataValid(dv2),
    .AlignFail(af2), .LossOfLock(lol2), .SlipCount(sc2)
  );

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({bit_slip, aligned, data_valid, align_fail, loss_of_lock} !== 5'b0 ||
        slip_count !== 6'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b sc=%0d, want 00000 sc=0",
               {bit_slip, aligned, data_valid, align_fail, loss_of_lock},
               slip_count);
    end
    rst = 1'b0;
    fixed_word = 16'hFF80;
    repeat (20) @(negedge clk);
    tests++;
    if (aligned !== 1'b0 || bit_slip !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_start: aligned=%b bitslip=%b, want 0 0",
               aligned, bit_slip);
    end
  endtask

  task automatic test_direct_lock();
    int slips = 0;
    fixed_word = 16'hFF80;
    pulse_start();
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (bit_slip) slips++;
      if (k == 11) begin
        tests++;
        if (aligned !== 1'b0) begin
          fails++;
          $display("FAIL direct_early: aligned=%b at k=11, want 0", aligned);
        end
      end
      if (k == 12) begin
        tests++;
        if (aligned !== 1'b1 || data_valid !== 1'b0) begin
          fails++;
          $display("FAIL direct_lock: aligned=%b dv=%b at k=12, want 1 0",
                   aligned, data_valid);
        end
      end
    end
    tests++;
    if (data_valid !== 1'b1 || slip_count !== 6'd0 || slips != 0) begin
      fails++;
      $display("FAIL direct_dv: dv=%b sc=%0d slips=%0d, want 1 0 0",
               data_valid, slip_count, slips);
    end
  endtask

  task automatic test_rotated();
    int last = -100;
    int k = 0;
    int popped;
    off = 3;
    use_rot = 1'b1;
    for (int i = 1; i <= 3; i++) exp_q.push_back(i);
    pulse_start();
    while (aligned !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
      if (bit_slip) begin
        tests++;
        popped = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        if (slip_count !== 6'(popped) || k - last < 6) begin
          fails++;
          $display("FAIL rot_slip: sc=%0d gap=%0d, want sc=%0d gap>=6",
                   slip_count, k - last, popped);
        end
        last = k;
      end
    end
    tests++;
    if (aligned !== 1'b1 || slip_count !== 6'd3 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL rot_lock: aligned=%b sc=%0d left=%0d, want 1 3 0",
               aligned, slip_count, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_loss();
    logic [15:0] seq [8];
    int k = 0;
    int bad = 0;
    seq = '{16'h0, 16'h0, 16'h0, 16'h3F80,
            16'h0, 16'h0, 16'h0, 16'h3F80};
    use_rot = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fixed_word = seq[i];
      @(negedge clk);
      if (aligned !== 1'b1 || loss_of_lock !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL loss_hold: %0d bad cycles, want 0", bad);
    end
    fixed_word = 16'h0;
    repeat (3) @(negedge clk);
    tests++;
    if (aligned !== 1'b1 || loss_of_lock !== 1'b0) begin
      fails++;
      $display("FAIL loss_early: aligned=%b lol=%b, want 1 0",
               aligned, loss_of_lock);
    end
    @(negedge clk);
    tests++;
    if (aligned !== 1'b0 || loss_of_lock !== 1'b1) begin
      fails++;
      $display("FAIL loss_pulse: aligned=%b lol=%b, want 0 1",
               aligned, loss_of_lock);
    end
    fixed_word = 16'h3F80;
    @(negedge clk);
    tests++;
    if (loss_of_lock !== 1'b0) begin
      fails++;
      $display("FAIL loss_width: lol=%b, want 0", loss_of_lock);
    end
    while (aligned !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
      if (bit_slip) bad++;
    end
    tests++;
    if (aligned !== 1'b1 || bad != 0 || k != 11) begin
      fails++;
      $display("FAIL loss_relock: aligned=%b slips=%0d k=%0d, want 1 0 11",
               aligned, bad, k);
    end
  endtask

  task automatic test_loss_start_collision();
    int k = 0;
    fixed_word = 16'h0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (loss_of_lock !== 1'b1 || aligned !== 1'b0) begin
      fails++;
      $display("FAIL collide_pulse: lol=%b aligned=%b, want 1 0",
               loss_of_lock, aligned);
    end
    fixed_word = 16'h3F80;
    @(negedge clk);
    tests++;
    if (loss_of_lock !== 1'b0) begin
      fails++;
      $display("FAIL collide_once: lol=%b, want 0", loss_of_lock);
    end
    while (aligned !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (aligned !== 1'b1) begin
      fails++;
      $display("FAIL collide_relock: aligned=%b, want 1", aligned);
    end
  endtask

  task automatic test_fail();
    int k = 0;
    int popped;
    int lol = 0;
    int slips = 0;
    fixed_word = 16'h0;
    for (int i = 1; i <= 28; i++) exp_q.push_back(i);
    pulse_start();
    tests++;
    if (aligned !== 1'b0 || loss_of_lock !== 1'b0) begin
      fails++;
      $display("FAIL start_locked: aligned=%b lol=%b, want 0 0",
               aligned, loss_of_lock);
    end
    while (align_fail !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
      if (loss_of_lock) lol++;
      if (bit_slip) begin
        popped = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        if (slip_count !== 6'(popped)) begin
          tests++;
          fails++;
          $display("FAIL fail_slip: sc=%0d, want %0d", slip_count, popped);
        end
      end
    end
    tests++;
    if (align_fail !== 1'b1 || slip_count !== 6'd28 ||
        exp_q.size() != 0 || lol != 0) begin
      fails++;
      $display("FAIL fail_state: af=%b sc=%0d left=%0d lol=%0d, want 1 28 0 0",
               align_fail, slip_count, exp_q.size(), lol);
    end
    exp_q.delete();
    repeat (20) begin
      @(negedge clk);
      if (bit_slip || !align_fail) slips++;
    end
    tests++;
    if (slips != 0) begin
      fails++;
      $display("FAIL fail_sticky: %0d bad cycles, want 0", slips);
    end
    pulse_start();
    tests++;
    if (align_fail !== 1'b0 || slip_count !== 6'd0) begin
      fails++;
      $display("FAIL fail_restart: af=%b sc=%0d, want 0 0",
               align_fail, slip_count);
    end
    k = 0;
    while (bit_slip !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (bit_slip !== 1'b1 || slip_count !== 6'd1 || k != 5) begin
      fails++;
      $display("FAIL fail_reslip: bs=%b sc=%0d k=%0d, want 1 1 5",
               bit_slip, slip_count, k);
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({bit_slip, aligned, data_valid, align_fail, loss_of_lock} !== 5'b0 ||
        slip_count !== 6'd0) begin
      fails++;
      $display("FAIL reset_async: got %b sc=%0d, want 00000 sc=0",
               {bit_slip, aligned, data_valid, align_fail, loss_of_lock},
               slip_count);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fixed_word = 16'h3F80;
    repeat (30) begin
      @(negedge clk);
      if (bit_slip || aligned) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL reset_wait: %0d active cycles, want 0", bad);
    end
    pulse_start();
    repeat (12) @(negedge clk);
    tests++;
    if (aligned !== 1'b1 || slip_count !== 6'd0) begin
      fails++;
      $display("FAIL reset_relock: aligned=%b sc=%0d, want 1 0",
               aligned, slip_count);
    end
  endtask

  task automatic test_upper_bits();
    int slips = 0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bs2) slips++;
    end
    tests++;
    if (al2 !== 1'b1 || slips != 0 || sc2 !== 6'd0 || af2 !== 1'b0) begin
      fails++;
      $display("FAIL upper_bits: aligned=%b slips=%0d sc=%0d af=%b, want 1 0 0 0",
               al2, slips, sc2, af2);
    end
    @(negedge clk);
    tests++;
    if (dv2 !== 1'b1 || lol2 !== 1'b0) begin
      fails++;
      $display("FAIL upper_dv: dv=%b lol=%b, want 1 0", dv2, lol2);
    end
  endtask

  initial begin
    test_reset();
    test_direct_lock();
    test_rotated();
    test_loss();
    test_loss_start_collision();
    test_fail();
    test_reset_mid();
    test_upper_bits();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_frame_align_ctrl.md
Name: adc_frame_align_ctrl

Overview:
Frame-alignment sequencer for the LVDS ADC receive path. It watches the deserialized frame-clock word and issues single-cycle bitslip pulses to the deserializers until the word matches the expected frame pattern. It then declares lock and gates the data-valid qualifier that follows the bit-reorder/sign-extend stage. Once locked, it keeps monitoring the frame word and re-aligns automatically on loss of lock.

Parameters:
AdcBits, 14, ADC resolution; only FrameWord[AdcBits-1:0] is compared (legal values 8/10/12/14/16).
FramePattern, 16'h3F80, expected frame word, right-justified; bits above AdcBits are ignored.
SettleCycles, 4, wait cycles after start and after every bitslip before comparing (>=1).
LockCount, 8, consecutive matches required to declare lock (>=1).
LossCount, 4, consecutive mismatches while locked that trigger re-alignment (>=1).
MaxSlips, 2*AdcBits, bitslips allowed per alignment attempt before failing.

Ports:
FrmClk  in  1  frame clock; all logic is on its rising edge.
Rst  in  1  asynchronous, active-high reset.
Start  in  1  single-cycle request to (re)start alignment.
FrameWord  in  16  deserialized frame-clock word, one word per FrmClk.
BitSlip  out  1  one-cycle bitslip pulse to all deserializers.
Aligned  out  1  high while in LOCKED.
DataValid  out  1  Aligned delayed by 1 cycle; matches the 1-cycle register stage in the data path.
AlignFail  out  1  high in FAIL; sticky until Start or Rst.
LossOfLock  out  1  one-cycle pulse when LOCKED is exited because of mismatches.
SlipCount  out  6  bitslips issued in the current attempt; saturates at 63.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE. BitSlip, Aligned, DataValid, AlignFail, LossOfLock=0. SlipCount=0. All internal counters=0.
- Match is defined as FrameWord[AdcBits-1:0] == FramePattern[AdcBits-1:0], evaluated combinationally each cycle.
- States: IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL.
- IDLE: Start -> SETTLE; clear SlipCount and settle/match counters.
- SETTLE: count SettleCycles cycles, then -> CHECK. Comparison results in this state are ignored.
- CHECK, on match: match counter +1; when it reaches LockCount -> LOCKED. Aligned rises on the edge that enters LOCKED.
- CHECK, on mismatch: clear match counter; if SlipCount == MaxSlips -> FAIL, else -> SLIP.
- SLIP: BitSlip=1 for exactly this one cycle; SlipCount +1; next state SETTLE. BitSlip is never asserted two cycles in a row.
- LOCKED: Aligned=1. Each mismatch increments the loss counter; any match clears it. When the loss counter reaches LossCount: LossOfLock pulses for 1 cycle, Aligned drops, SlipCount clears, state -> SETTLE (automatic re-align, no Start needed).
- FAIL: AlignFail=1, no BitSlip. Start -> SETTLE with AlignFail cleared and counters cleared.
- Start in SETTLE/CHECK/SLIP is ignored. Start in LOCKED forces a re-align: -> SETTLE, Aligned drops, no LossOfLock pulse.
- A Start arriving on the same cycle that LossCount is reached: the loss path wins (LossOfLock pulses once).
- Latency: with a correct word from the start, the Start edge to Aligned=1 takes 1+SettleCycles+LockCount cycles. DataValid follows Aligned one cycle later.
- Reset asserted mid-alignment returns to IDLE immediately, with no partial BitSlip pulse. After reset is released, the block waits for a fresh Start.
- Counters are sized with $clog2 of their limit plus 1 and never wrap.

Decomposition:
- Shared package adc_lvds_pkg: state enum (3-bit encoding), default frame patterns per resolution (8:8'hF0, 10:10'h3E0, 12:12'hFC0, 14:14'h3F80, 16:16'hFF00), and the SlipCount width constant.
- Sub-module adc_frame_match_filter: consecutive match/mismatch counter with LockCount/LossCount thresholds. It outputs lock_hit and loss_hit.
- The FSM stays in the top level.

Test Plan:
- FrameWord already 14'h3F80, Start at cycle 0 -> no BitSlip, Aligned=1 at cycle 13 (defaults), DataValid=1 at cycle 14, SlipCount=0.
- Bench model rotates the pattern by 3 bits; each BitSlip rotates it by 1 -> exactly 3 BitSlip pulses, each followed by at least 4 settle cycles; Aligned=1; SlipCount=3.
- Pattern never matches (FrameWord=0) -> 28 BitSlips, then AlignFail=1 and BitSlip stays 0; Start -> AlignFail clears and the slip sequence restarts.
- While locked, 3 mismatches then 1 match then 3 mismatches -> stays locked. Next, 4 consecutive mismatches -> LossOfLock is a 1-cycle pulse, Aligned=0, re-align begins without Start.
- Rst asserted the cycle after BitSlip, during SETTLE -> all outputs 0 asynchronously, state IDLE, no BitSlip after release until Start.
- AdcBits=12, FramePattern=16'hAFC0 (upper bits junk), FrameWord=16'h0FC0 -> locks with no bitslip, proving the upper bits are ignored.
